// File: rtl/i2c_reg_bank_if.sv
// Application bus between the I2C slave and the register bank.
// The slave drives address, direction and write strobes; the bank returns rdata.
`timescale 1ns/1ps
interface i2c_reg_bank_if;
  logic       rw;
  logic [7:0] addr;
  logic       wen;
  logic [7:0] wdata;
  logic       rdata_used;
  logic [7:0] rdata;

  // I2C slave side: issues accesses and captures read data
  modport master (
    output rw,
    output addr,
    output wen,
    output wdata,
    output rdata_used,
    input  rdata
  );

  // Register bank side: decodes accesses and supplies read data
  modport slave (
    input  rw,
    input  addr,
    input  wen,
    input  wdata,
    input  rdata_used,
    output rdata
  );
endinterface

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C slave: ID, CTRL (with LOCK), DATA0/1,
// synchronised STATUS, sticky EVT flags (W1C and clear-on-read),
// IRQ enable, write counter and eight scratch registers.
`timescale 1ns/1ps
module i2c_reg_bank #(
  parameter logic [7:0] DEVICE_ID = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_reg_bank_if.slave        bus,
  input  logic [7:0]           status_i,
  input  logic [7:0]           event_i,
  output logic [7:0]           ctrl_o,
  output logic [7:0]           data0_o,
  output logic [7:0]           data1_o,
  output logic                 irq_o
);

  // Register state
  logic [7:0] ctrl_r;
  logic [7:0] data0_r;
  logic [7:0] data1_r;
  logic [7:0] evt_r;
  logic [7:0] irq_en_r;
  logic [7:0] wcnt_r;
  logic [7:0] scratch_r [8];
  logic [7:0] status_meta_r;
  logic [7:0] status_sync_r;
  logic [7:0] rdata_r;
  logic       irq_r;

  // Decode and next-state signals
  logic       in_range_s;
  logic       wr_req_s;
  logic       lock_s;
  logic       sel_ctrl_s;
  logic       sel_data0_s;
  logic       sel_data1_s;
  logic       sel_evt_s;
  logic       sel_irq_en_s;
  logic       sel_scratch_s;
  logic       wr_ctrl_s;
  logic       wr_data0_s;
  logic       wr_data1_s;
  logic       wr_evt_s;
  logic       wr_irq_en_s;
  logic       wr_scratch_s;
  logic       wr_accept_s;
  logic       rd_evt_used_s;
  logic [7:0] evt_clr_s;
  logic [7:0] evt_next_s;
  logic [7:0] map_data_s;
  logic [7:0] rd_data_s;

  // Write decode: pick the target register, then gate with strobe, range and LOCK
  always_comb begin
    in_range_s    = (bus.addr[7:4] == 4'h0);
    wr_req_s      = bus.wen && !bus.rw && in_range_s;
    lock_s        = ctrl_r[7];
    sel_ctrl_s    = 1'b0;
    sel_data0_s   = 1'b0;
    sel_data1_s   = 1'b0;
    sel_evt_s     = 1'b0;
    sel_irq_en_s  = 1'b0;
    sel_scratch_s = 1'b0;
    case (bus.addr[3:0])
      4'h1:    sel_ctrl_s    = 1'b1;
      4'h2:    sel_data0_s   = 1'b1;
      4'h3:    sel_data1_s   = 1'b1;
      4'h5:    sel_evt_s     = 1'b1;
      4'h6:    sel_irq_en_s  = 1'b1;
      default: sel_scratch_s = bus.addr[3];
    endcase
    // CTRL, EVT and IRQ_EN ignore LOCK so the master can always unlock
    wr_ctrl_s    = wr_req_s && sel_ctrl_s;
    wr_evt_s     = wr_req_s && sel_evt_s;
    wr_irq_en_s  = wr_req_s && sel_irq_en_s;
    wr_data0_s   = wr_req_s && sel_data0_s   && !lock_s;
    wr_data1_s   = wr_req_s && sel_data1_s   && !lock_s;
    wr_scratch_s = wr_req_s && sel_scratch_s && !lock_s;
    wr_accept_s  = wr_ctrl_s || wr_evt_s || wr_irq_en_s ||
                   wr_data0_s || wr_data1_s || wr_scratch_s;
  end

  // EVT next value: clear from W1C data and from the captured read snapshot; new events win
  always_comb begin
    rd_evt_used_s = bus.rdata_used && (bus.addr == 8'h05);
    evt_clr_s     = (wr_evt_s ? bus.wdata : 8'h00) |
                    (rd_evt_used_s ? rdata_r : 8'h00);
    evt_next_s    = (evt_r & ~evt_clr_s) | event_i;
  end

  // Read mux: register map for the low nibble, zero when out of range
  always_comb begin
    case (bus.addr[3:0])
      4'h0:    map_data_s = DEVICE_ID;
      4'h1:    map_data_s = ctrl_r;
      4'h2:    map_data_s = data0_r;
      4'h3:    map_data_s = data1_r;
      4'h4:    map_data_s = status_sync_r;
      4'h5:    map_data_s = evt_r;
      4'h6:    map_data_s = irq_en_r;
      4'h7:    map_data_s = wcnt_r;
      default: map_data_s = scratch_r[bus.addr[2:0]];
    endcase
    rd_data_s = in_range_s ? map_data_s : 8'h00;
  end

  // Read/write control registers and the write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= 8'h00;
      data0_r  <= 8'h00;
      data1_r  <= 8'h00;
      irq_en_r <= 8'h00;
      wcnt_r   <= 8'h00;
    end else begin
      if (wr_ctrl_s)   ctrl_r   <= bus.wdata;
      if (wr_data0_s)  data0_r  <= bus.wdata;
      if (wr_data1_s)  data1_r  <= bus.wdata;
      if (wr_irq_en_s) irq_en_r <= bus.wdata;
      if (wr_accept_s) wcnt_r   <= wcnt_r + 8'h01;
    end
  end

  // Scratch register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        scratch_r[i] <= 8'h00;
      end
    end else if (wr_scratch_s) begin
      scratch_r[bus.addr[2:0]] <= bus.wdata;
    end
  end

  // Sticky event flags and the registered interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_r <= 8'h00;
      irq_r <= 1'b0;
    end else begin
      evt_r <= evt_next_s;
      irq_r <= |(evt_r & irq_en_r);
    end
  end

  // Two-flop synchroniser for the asynchronous status levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_meta_r <= 8'h00;
      status_sync_r <= 8'h00;
    end else begin
      status_meta_r <= status_i;
      status_sync_r <= status_meta_r;
    end
  end

  // Registered read data; its value is the snapshot used for clear-on-read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 8'h00;
    end else begin
      rdata_r <= rd_data_s;
    end
  end

  assign bus.rdata = rdata_r;
  assign ctrl_o    = ctrl_r;
  assign data0_o   = data0_r;
  assign data1_o   = data1_r;
  assign irq_o     = irq_r;

endmodule

// File: doc/i2c_reg_bank.md
# i2c_reg_bank

Application-side register bank that sits directly downstream of the I2C slave. It consumes the slave's application bus (`rw`, `addr`, `wen`, `wdata`, `rdata_used`) and returns `rdata`. It holds control and scratch registers, synchronised status inputs, sticky event flags with clear-on-read, an interrupt output and a write counter. The I2C master sees a 16-byte register map through it.

## Interface
- `DEVICE_ID`, 8'hA5: constant value returned at register 0x0.
- `clk` input 1: system clock, same clock as the I2C slave.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rw` input 1: transaction direction from the slave (1 = read, 0 = write).
- `addr` input 8: register address from the slave.
- `wen` input 1: one-cycle write strobe from the slave.
- `wdata` input 8: write data, valid while `wen`=1.
- `rdata_used` input 1: one-cycle pulse. The slave has captured `rdata`.
- `rdata` output 8: read data for the current `addr`.
- `status_i` input 8: asynchronous status levels.
- `event_i` input 8: synchronous one-cycle event pulses.
- `ctrl_o` output 8: CTRL register.
- `data0_o` output 8: DATA0 register.
- `data1_o` output 8: DATA1 register.
- `irq_o` output 1: interrupt, active-high level.

## Operation
- Address decode:
  - `addr[7:4]` != 0 is out of range. Reads return 0x00 and writes are ignored.
  - Only `addr[3:0]` selects a register.
- Register map (reset values in brackets):
  - 0x0 ID, read-only, returns `DEVICE_ID`.
  - 0x1 CTRL, read/write [0x00]. Bit 7 = LOCK.
  - 0x2 DATA0, read/write [0x00].
  - 0x3 DATA1, read/write [0x00].
  - 0x4 STATUS, read-only. Returns `status_i` through a 2-flop synchroniser. Both flops reset to 0.
  - 0x5 EVT, sticky flags [0x00].
  - 0x6 IRQ_EN, read/write [0x00].
  - 0x7 WCNT, read-only [0x00].
  - 0x8–0xF SCRATCH0..7, read/write [0x00].
- Write acceptance:
  - A write occurs only when `wen`=1, `rw`=0 and the address is in range.
  - Writes to read-only addresses (0x0, 0x4, 0x7) are not accepted.
  - When LOCK=1, writes to DATA0, DATA1 and SCRATCH are not accepted.
  - CTRL, EVT and IRQ_EN are always writable, so a master can clear LOCK.
- WCNT:
  - Increments by 1 for every accepted write, including writes to CTRL, EVT and IRQ_EN.
  - 8-bit, wraps from 0xFF to 0x00. Ignored writes do not count.
- EVT flags:
  - Bit n sets when `event_i[n]`=1.
  - Clear by writing 1 (a write to 0x5 clears the bits where `wdata`=1).
  - Clear on read: when `rdata_used`=1 with `addr`=0x05, the bits that were 1 in the `rdata` value being captured are cleared.
  - Set and clear in the same cycle: set wins and the bit stays 1.
- `irq_o` is registered and equals |(EVT & IRQ_EN) of the previous cycle.
- `ctrl_o`, `data0_o` and `data1_o` are the register outputs directly; there is no extra stage.

## Timing
- Async reset: every register, flag, synchroniser flop and output goes to 0 immediately; `rdata`=0x00, `irq_o`=0. Reset mid-transaction discards everything; the slave restarts on its own.
- Write: the register updates on the clock edge where `wen`=1. The new value is visible on its output port in the next cycle.
- WCNT updates on that same edge.
- `rdata` is registered: `rdata` in cycle t+1 = map[`addr` in cycle t].
  - The slave holds `addr` stable for at least 2 `clk` cycles before asserting `rdata_used`, because an I2C bit period spans many `clk` cycles.
  - The bank adds no wait states and no handshake.
- Read data is a snapshot: the flags cleared on read are exactly those in the registered `rdata` value. An event arriving in the read cycle is kept.
- `rdata_used` with any `addr` other than 0x05 has no side effects.
- The slave's auto-increment past 0x0F lands out of range and reads 0x00. There is no wrap to 0x00 inside the bank.
- STATUS latency is 2 cycles from `status_i` to the synchroniser output, then 1 more cycle to `rdata`.
- `irq_o` latency from an `event_i` pulse (with its enable set) is 2 cycles: flag set, then IRQ register.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 asynchronously mid-cycle after loading registers.
  - Required: all outputs go to 0 immediately; after release, reading 0x0 returns 0xA5.
- Write/readback and lock:
  - Stimulus: write 0x3C to 0x2, then 0x80 to 0x1, then 0xFF to 0x2.
  - Required: `data0_o` stays 0x3C; WCNT reads 0x02.
- Out of range and read-only:
  - Stimulus: write to 0x07 and to 0x20.
  - Required: WCNT unchanged; reading 0x20 returns 0x00.
- Events and clear on read:
  - Stimulus: pulse `event_i`=0x05, set IRQ_EN=0x04.
  - Required: `irq_o`=1 two cycles after the pulse.
  - Stimulus: read 0x05 with `rdata_used` while `event_i`=0x01 arrives in the same cycle.
  - Required: `rdata`=0x05 and EVT afterwards = 0x01.
- W1C with simultaneous set:
  - Stimulus: write 0x01 to 0x5 in the same cycle as `event_i[0]`=1.
  - Required: bit 0 stays 1.
- WCNT wrap:
  - Stimulus: perform 256 accepted writes.
  - Required: WCNT reads 0x00.
